// File: rtl/crc_stage_sequencer.sv
// crc_stage_sequencer: ap_ctrl_hs sequencer for crc24a loop stages with per-stage watchdog; optional perf counters under SEQ_PERF_CNT_EN
module crc_stage_sequencer #(
  parameter int N_STAGES = 6,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_W = 32,
  localparam int IW = $clog2(N_STAGES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_idle,
  input  logic [N_STAGES-1:0]  stage_mask,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 clear_err,
  output logic [N_STAGES-1:0]  stg_start,
  input  logic [N_STAGES-1:0]  stg_ready,
  input  logic [N_STAGES-1:0]  stg_done,
  output logic [IW-1:0]        cur_stage,
  output logic                 error,
  output logic [IW-1:0]        err_stage,
  input  logic [IW-1:0]        perf_sel,
  output logic [CNT_W-1:0]     perf_cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  state_t state, state_n;
  logic [N_STAGES-1:0] mask_q;
  logic [IW-1:0] idx, err_q, first_idx, next_idx;
  logic next_any, gap, rdy_q, active, done_hit, wd_hit, launch;
  logic [TIMEOUT_W-1:0] wd;
  assign launch = state == IDLE && ap_start;
  assign active = state == RUN && !gap;
  assign done_hit = active && stg_done[idx];
  assign wd_hit = active && !stg_done[idx] && timeout_limit != '0 && wd + TIMEOUT_W'(1) == timeout_limit;
  assign stg_start = (active && !rdy_q) ? N_STAGES'(1) << idx : '0;
  assign cur_stage = state == RUN ? idx : '0;
  assign ap_idle = state == IDLE;
  assign ap_done = state == DONE;
  assign ap_ready = state == DONE;
  assign error = state == ERR;
  assign err_stage = err_q;
  // lowest set bit of the incoming mask, and the next set bit above idx in the latched mask
  always_comb begin
    first_idx = '0;
    next_idx = '0;
    next_any = 1'b0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (stage_mask[i]) first_idx = IW'(i);
      if (mask_q[i] && IW'(i) > idx) begin
        next_idx = IW'(i);
        next_any = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next-state: completion wins over a watchdog hit in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (ap_start) state_n = |stage_mask ? RUN : DONE;
      RUN:  state_n = (done_hit && !next_any) ? DONE : (!done_hit && wd_hit) ? ERR : RUN;
      DONE: state_n = IDLE;
      ERR:  state_n = clear_err ? IDLE : ERR;
      default: state_n = IDLE;
    endcase
  end
  // stage index, inter-stage gap, ready capture, watchdog and error stage
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mask_q <= '0;
      idx <= '0;
      gap <= 1'b0;
      rdy_q <= 1'b0;
      wd <= '0;
      err_q <= '0;
    end else begin
      if (launch) begin
        mask_q <= stage_mask;
        idx <= first_idx;
        gap <= 1'b0;
        rdy_q <= 1'b0;
        wd <= '0;
      end else if (done_hit) begin
        idx <= next_any ? next_idx : idx;
        gap <= 1'b1;
        rdy_q <= 1'b0;
        wd <= '0;
      end else if (state == RUN && gap) begin
        gap <= 1'b0;
      end else if (active) begin
        wd <= wd + TIMEOUT_W'(1);
        if (stg_ready[idx]) rdy_q <= 1'b1;
        if (wd_hit) err_q <= idx;
      end
      if (state == ERR && clear_err) err_q <= '0;
    end
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt [N_STAGES];
  // saturating per-stage active-cycle counters, cleared on launch
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < N_STAGES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_STAGES; i++)
        if (launch) cnt[i] <= '0;
        else if (active && idx == IW'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  // registered readout; out-of-range selects read zero
  always_ff @(posedge clock or posedge reset)
    if (reset) perf_cycles <= '0;
    else perf_cycles <= 32'(perf_sel) < N_STAGES ? cnt[perf_sel] : '0;
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel;
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_crc_stage_sequencer.sv
// tb_crc_stage_sequencer: directed checks of stage ordering, gaps, watchdog, async reset and perf readout
module tb_crc_stage_sequencer;
  logic clock = 0, reset = 1, ap_start = 0, clear_err = 0;
  logic ap_ready, ap_done, ap_idle, error;
  logic [5:0] stage_mask = 0, stg_start, stg_ready = 0, stg_done = 0;
  logic [15:0] timeout_limit = 0;
  logic [2:0] cur_stage, err_stage, perf_sel = 0;
  logic [31:0] perf_cycles;
  int total = 0, bad = 0;
  int dly_t[6], hang = -1, stop_stage = -1, rdy_en = 1;
  int st_stage[8], st_cyc[8], st_cur[8], n_st, multi, err_cyc;
  crc_stage_sequencer dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .stage_mask(stage_mask),
    .timeout_limit(timeout_limit), .clear_err(clear_err), .stg_start(stg_start),
    .stg_ready(stg_ready), .stg_done(stg_done), .cur_stage(cur_stage),
    .error(error), .err_stage(err_stage), .perf_sel(perf_sel), .perf_cycles(perf_cycles)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  // launch mask m and act as the stages: ready on entry (if enabled), done dly_t[s] cycles after entry
  task automatic run_seq(input logic [5:0] m);
    int cyc = 0, k = 0, s = 0, fin = 0;
    logic act = 0;
    n_st = 0; multi = 0; err_cyc = -1;
    stage_mask = m; ap_start = 1;
    tick;
    ap_start = 0; stage_mask = ~m;
    while (cyc < 200 && !fin) begin
      stg_ready = rdy_en != 0 ? stg_start : 6'h0;
      stg_done = 0;
      if ($countones(stg_start) > 1) multi++;
      if (!act && stg_start != 0) begin
        for (int i = 0; i < 6; i++) if (stg_start[i]) s = i;
        st_stage[n_st] = s; st_cyc[n_st] = cyc; st_cur[n_st] = int'(cur_stage);
        n_st++; act = 1; k = 0;
        if (s == stop_stage) fin = 1;
      end else if (act) k++;
      if (!fin && act && k == dly_t[s] && s != hang) begin
        stg_done = 6'b1 << s;
        act = 0;
      end
      if (error) err_cyc = cyc;
      if (ap_done || error) fin = 1;
      if (!fin) begin
        tick;
        cyc++;
      end
    end
    chk("terminated", 32'(fin), 1);
    stg_ready = 0; stg_done = 0;
  endtask
  initial begin
    for (int i = 0; i < 6; i++) dly_t[i] = 4;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", {ap_done, ap_ready}, 0);
    chk("rst_start", stg_start, 0);
    chk("rst_err", {error, err_stage}, 0);
    chk("rst_cur", cur_stage, 0);
    chk("rst_perf", perf_cycles, 0);
    // all six stages, done 4 cycles after entry: next start 6 cycles later (1 gap)
    run_seq(6'h3F);
    chk("all_n", n_st, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("all_stage%0d", i), st_stage[i], i);
    for (int i = 1; i < 6; i++) chk($sformatf("all_spacing%0d", i), st_cyc[i] - st_cyc[i-1], 6);
    chk("all_multi", multi, 0);
    chk("all_ready", ap_ready, 1);
    chk("all_err", error, 0);
    tick;
    chk("all_pulse", ap_done, 0);
    chk("all_idle", ap_idle, 1);
    // sparse mask
    run_seq(6'b100101);
    chk("sp_n", n_st, 3);
    chk("sp_s0", st_stage[0], 0); chk("sp_s1", st_stage[1], 2); chk("sp_s2", st_stage[2], 5);
    chk("sp_c0", st_cur[0], 0); chk("sp_c1", st_cur[1], 2); chk("sp_c2", st_cur[2], 5);
    tick;
    // empty mask: straight to DONE
    stage_mask = 0; ap_start = 1;
    tick;
    ap_start = 0;
    chk("m0_done", {ap_done, ap_ready}, 2'b11);
    chk("m0_start", stg_start, 0);
    chk("m0_idle", ap_idle, 0);
    tick;
    chk("m0_after", {ap_done, ap_idle}, 2'b01);
    // watchdog: stage 2 never completes, ERR after 10 RUN cycles in stage 2
    timeout_limit = 10; hang = 2; dly_t = '{2, 2, 2, 2, 2, 2};
    run_seq(6'h3F);
    chk("wd_n", n_st, 3);
    chk("wd_cyc", err_cyc - st_cyc[2], 10);
    chk("wd_err", error, 1);
    chk("wd_stage", err_stage, 2);
    chk("wd_start", stg_start, 0);
    chk("wd_idle", ap_idle, 0);
    ap_start = 1;
    tick;
    ap_start = 0;
    chk("wd_sticky", {error, ap_idle}, 2'b10);
    clear_err = 1;
    tick;
    clear_err = 0;
    chk("clr_idle", ap_idle, 1);
    chk("clr_err", {error, err_stage}, 0);
    // async reset while stage 3 is being started (ready withheld so start stays high)
    timeout_limit = 0; hang = -1; dly_t = '{4, 4, 4, 4, 4, 4};
    rdy_en = 0; stop_stage = 3;
    run_seq(6'h3F);
    chk("rs_pre", stg_start, 6'b001000);
    chk("rs_cur", cur_stage, 3);
    #2 reset = 1;
    #1;
    chk("rs_start", stg_start, 0);
    chk("rs_idle", ap_idle, 1);
    chk("rs_cur0", cur_stage, 0);
    #1 reset = 0;
    rdy_en = 1; stop_stage = -1;
    // restart from stage 0; stage 1 done in its 7th cycle for the perf counter
    dly_t[1] = 6;
    run_seq(6'h3F);
    chk("re_n", n_st, 6);
    chk("re_first", st_stage[0], 0);
    perf_sel = 1;
    tick;
`ifdef SEQ_PERF_CNT_EN
    chk("perf1", perf_cycles, 7);
`else
    chk("perf1", perf_cycles, 0);
`endif
    perf_sel = 0;
    tick;
`ifdef SEQ_PERF_CNT_EN
    chk("perf0", perf_cycles, 5);
`else
    chk("perf0", perf_cycles, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
